// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin sharing of the rom SPI-flash read port between fetch (A) and data (B).
// Define FLASH_ARB_LASTWORD_EN to add a one-word per-port hit buffer that bypasses flash.
module flash_arbiter #(
  parameter int          ADDR_W     = 15,
  parameter int          DATA_W     = 16,
  parameter logic [23:0] FLASH_BASE = 24'h100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_data,
  input  logic              rom_ready,
  output logic              rom_req,
  output logic [23:0]       rom_addr,
  input  logic              rom_valid,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              gnt, gnt_nx;     // 1 = port B owns the current transaction
  logic              last_b;          // last completed grant went to B
  logic              pick_b;
  logic [ADDR_W-1:0] pick_addr;

  function automatic logic [23:0] byte_addr(input logic [ADDR_W-1:0] word);
    return FLASH_BASE + (24'(word) << 1);
  endfunction

  // Lone requester wins; on a conflict the port not served last time wins.
  assign pick_b    = b_req && (!a_req || !last_b);
  assign pick_addr = pick_b ? b_addr : a_addr;

`ifdef FLASH_ARB_LASTWORD_EN
  // The port data registers double as buffer data: both load only on flash-path acks.
  logic [1:0]             lw_vld;
  logic [1:0][ADDR_W-1:0] lw_addr;
  logic [ADDR_W-1:0]      pend_addr;
  logic                   lw_hit;

  assign lw_hit = lw_vld[pick_b] && (lw_addr[pick_b] == pick_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_vld    <= '0;
      lw_addr   <= '0;
      pend_addr <= '0;
    end else begin
      if (state == IDLE) pend_addr <= pick_addr;
      if (state == WAIT && rom_valid) begin
        lw_vld[gnt]  <= 1'b1;
        lw_addr[gnt] <= pend_addr;
      end
    end
  end
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      IDLE: begin
        if (rom_ready && (a_req || b_req)) begin
          gnt_nx = pick_b;
`ifdef FLASH_ARB_LASTWORD_EN
          state_nx = lw_hit ? RESP : ISSUE;
`else
          state_nx = ISSUE;
`endif
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (rom_valid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_b   <= 1'b1;
      rom_req  <= 1'b0;
      rom_addr <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      rom_req <= (state_nx == ISSUE);
      a_ack   <= (state_nx == RESP) && !gnt_nx;
      b_ack   <= (state_nx == RESP) && gnt_nx;
      if (state == IDLE && state_nx == ISSUE) rom_addr <= byte_addr(pick_addr);
      if (state == WAIT && rom_valid) begin
        if (gnt) b_data <= rom_data;
        else     a_data <= rom_data;
      end
      if (state == RESP) last_b <= gnt;
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed scenarios followed by random traffic, checked every cycle
// against a transaction-timeline model of the arbiter and a behavioural rom responder.
module tb_flash_arbiter;
  localparam int          ADDR_W = 15;
  localparam int          DATA_W = 16;
  localparam logic [23:0] BASE   = 24'h100000;
  localparam logic [23:0] BASE_W = 24'hFFFFFE;
`ifdef FLASH_ARB_LASTWORD_EN
  localparam bit LW = 1'b1;
`else
  localparam bit LW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0, rom_ready = 1'b1, rom_valid = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] rom_data = '0;
  logic a_ack, b_ack, rom_req, w_a_ack, w_b_ack, w_rom_req;
  logic [DATA_W-1:0] a_data, b_data, w_a_data, w_b_data;
  logic [23:0] rom_addr, w_rom_addr;

  always #5 clk = ~clk;

  flash_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLASH_BASE(BASE)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data),
    .rom_ready(rom_ready), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_valid(rom_valid), .rom_data(rom_data));

  flash_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLASH_BASE(BASE_W)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(w_a_ack), .a_data(w_a_data),
    .b_req(b_req), .b_addr(b_addr), .b_ack(w_b_ack), .b_data(w_b_data),
    .rom_ready(rom_ready), .rom_req(w_rom_req), .rom_addr(w_rom_addr),
    .rom_valid(rom_valid), .rom_data(rom_data));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: one outstanding transaction described by its cycle timeline.
  bit                busy, hit_m, port, last_b, keep_a, keep_b, rec, ack_now, exp_rq, stray_ok;
  int                req_cyc, valid_cyc, ack_cyc, free_cyc, lat, lat_force;
  logic [ADDR_W-1:0] exp_a;
  logic [23:0]       exp_addr, exp_waddr;
  logic [DATA_W-1:0] exp_data, a_val, b_val, fix_data;
  bit                fix_en;
  bit [1:0]          bv;
  logic [ADDR_W-1:0] baddr [2];
  logic [DATA_W-1:0] bdata [2];
  bit                order [$];

  function automatic logic [23:0] flash_byte(input logic [23:0] base, input logic [ADDR_W-1:0] w);
    return base + 24'(2 * int'(w));
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  task automatic model_reset();
    busy = 0; hit_m = 0; a_val = '0; b_val = '0; last_b = 1; bv = '0;
    a_req = 0; b_req = 0; keep_a = 0; keep_b = 0;
    req_cyc = -10; valid_cyc = -10; ack_cyc = -10;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_req"}, rom_req, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_w_rom_addr"}, w_rom_addr, 0);
    check({tag, "_a_ack"}, a_ack, 0);
    check({tag, "_b_ack"}, b_ack, 0);
    check({tag, "_a_data"}, a_data, 0);
    check({tag, "_b_data"}, b_data, 0);
  endtask

  initial begin
    model_reset();
    fix_en = 0; fix_data = '0; lat_force = 0; rec = 0; free_cyc = 0; port = 0;
    #1 check_zero("rst");
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rom_valid = 1'b0;
      if (c == 0) begin reset_n = 1'b1; free_cyc = 0; end
      if (c == 143) begin reset_n = 1'b0; #1; model_reset(); end
      if (c == 146) begin reset_n = 1'b1; free_cyc = c; end
      if (!reset_n) begin check_zero("mid_rst"); continue; end

      // Outputs expected in this cycle
      exp_rq = busy && !hit_m && (c == req_cyc);
      check("rom_req", rom_req, exp_rq);
      check("w_rom_req", w_rom_req, exp_rq);
      if (busy && !hit_m && c >= req_cyc && c <= valid_cyc) begin
        check("rom_addr", rom_addr, exp_addr);
        check("w_rom_addr", w_rom_addr, exp_waddr);
      end
      ack_now = busy && (c == ack_cyc);
      if (ack_now) begin
        if (port) b_val = exp_data;
        else      a_val = exp_data;
      end
      check("a_ack", a_ack, ack_now && !port);
      check("b_ack", b_ack, ack_now && port);
      check("w_a_ack", w_a_ack, ack_now && !port);
      check("w_b_ack", w_b_ack, ack_now && port);
      check("a_data", a_data, a_val);
      check("b_data", b_data, b_val);
      check("w_a_data", w_a_data, a_val);
      check("w_b_data", w_b_data, b_val);

      // Transaction completion and requester reaction
      if (ack_now) begin
        busy = 0; last_b = port; free_cyc = c + 1;
        if (!hit_m) begin bv[port] = 1; baddr[port] = exp_a; bdata[port] = exp_data; end
        if (rec) order.push_back(port);
        if (!port) begin
          if (keep_a) a_addr = pick_addr(); else a_req = 0;
        end else begin
          if (keep_b) b_addr = pick_addr(); else b_req = 0;
        end
      end

      // Directed scenarios
      if (c == 1)   begin a_req = 1; a_addr = 15'h0003; fix_en = 1; fix_data = 16'hBEEF; lat_force = 5; end
      if (c == 2)   begin check("base_addr", rom_addr, 24'h100006); check("wrap_small", w_rom_addr, 24'h000004); end
      if (c == 8)   check("beef_data", a_data, 16'hBEEF);
      if (c == 10)  begin fix_en = 0; lat_force = 0; end
      if (c == 15)  begin rom_ready = 0; a_req = 1; a_addr = 15'h1234; end
      if (c == 35)  rom_ready = 1;
      if (c == 36)  check("ready_req", rom_req, 1);
      if (c == 60)  begin a_req = 1; b_req = 1; a_addr = pick_addr(); b_addr = pick_addr();
                          keep_a = 1; keep_b = 1; rec = 1; end
      if (c == 100) begin keep_a = 0; keep_b = 0; rec = 0; end
      if (c == 101) begin
        check("rr_count", order.size() >= 4, 1);
        for (int i = 1; i < 4; i++) check("rr_alt", order[i], !order[i-1]);
      end
      if (c == 138) begin a_req = 1; a_addr = pick_addr(); lat_force = 8; end
      if (c == 150) lat_force = 0;
      if (c == 152) begin a_req = 1; a_addr = 15'h0042; end
      if (c == 170) begin a_req = 1; a_addr = 15'h7FFF; end
      if (c == 171) begin check("max_req", rom_req, 1); check("max_addr", rom_addr, 24'h10FFFE);
                          check("wrap_addr", w_rom_addr, 24'h00FFFC); end
      if (c == 190) begin a_req = 1; a_addr = 15'h0010; end
      if (c == 205) begin a_req = 1; a_addr = 15'h0010; end
      if (c == 206) begin check("lw_repeat_req", rom_req, !LW); check("lw_repeat_ack", a_ack, LW); end
      if (c == 220) begin a_req = 1; a_addr = 15'h0011; end
      if (c == 221) check("lw_other_req", rom_req, 1);

      // Random traffic
      if (c >= 240 && c < 2980) begin
        if (!a_req && $urandom_range(0, 99) < 30) begin
          a_req = 1; a_addr = pick_addr(); keep_a = ($urandom_range(0, 3) == 0);
        end
        if (!b_req && $urandom_range(0, 99) < 30) begin
          b_req = 1; b_addr = pick_addr(); keep_b = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 99) < 3) rom_ready = ~rom_ready;
      end
      if (c == 2980) begin keep_a = 0; keep_b = 0; rom_ready = 1; end

      // rom responder, plus stray strobes whenever the arbiter is not waiting
      rom_data = DATA_W'($urandom);
      stray_ok = !busy || hit_m || (c == req_cyc) || (c == ack_cyc);
      if (busy && !hit_m && c == valid_cyc) begin
        rom_valid = 1; rom_data = exp_data;
      end else if (stray_ok && (c == 147 || (c >= 240 && $urandom_range(0, 99) < 10))) begin
        rom_valid = 1;
      end

      // Arbitration at the next edge
      if (!busy && c >= free_cyc && rom_ready && (a_req || b_req)) begin
        port  = (a_req && b_req) ? !last_b : b_req;
        exp_a = port ? b_addr : a_addr;
        busy  = 1;
        hit_m = LW && bv[port] && (baddr[port] == exp_a);
        if (hit_m) begin
          exp_data = bdata[port];
          req_cyc = -10; valid_cyc = -10; ack_cyc = c + 1;
        end else begin
          lat       = (lat_force != 0) ? lat_force : $urandom_range(1, 4);
          req_cyc   = c + 1;
          valid_cyc = req_cyc + lat;
          ack_cyc   = valid_cyc + 1;
          exp_addr  = flash_byte(BASE, exp_a);
          exp_waddr = flash_byte(BASE_W, exp_a);
          exp_data  = fix_en ? fix_data : DATA_W'($urandom);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
